// File: rtl/hdmi_line_fetch_ctrl.sv
// hdmi_line_fetch_ctrl
//   Fetches 720p frame-buffer lines over a burst-read bus into a two-bank
//   (ping-pong) line buffer. The display reads bank readBank while the other
//   bank is filled. Lines that are not complete when the display needs them
//   raise a sticky underrun flag.
// Ports
//   pixelClockIn, resetN        clock, synchronous active-low reset
//   enable                      run / finish current burst then idle
//   frameBufferBase             byte address of line 0 (taken on newScreen)
//   newScreen, nextLine         timing-generator strobes
//   busRequest/Grant/Address/BurstSize, busDataValid/Data   read bus
//   lineBufWe/Addr/Data         line-buffer write port ({bank, word})
//   readBank, underrun, fetchedLines   display-side status
module hdmi_line_fetch_ctrl #(
  parameter int BURST_SIZE  = 16,
  parameter int LINE_WORDS  = 640,
  parameter int NR_OF_LINES = 720
) (
  input  logic        pixelClockIn,
  input  logic        resetN,
  input  logic        enable,
  input  logic [31:0] frameBufferBase,
  input  logic        newScreen,
  input  logic        nextLine,
  output logic        busRequest,
  input  logic        busGrant,
  output logic [31:0] busAddress,
  output logic [7:0]  busBurstSize,
  input  logic        busDataValid,
  input  logic [31:0] busData,
  output logic        lineBufWe,
  output logic [10:0] lineBufAddr,
  output logic [31:0] lineBufData,
  output logic        readBank,
  output logic        underrun,
  output logic [9:0]  fetchedLines
);

  typedef enum logic [2:0] {IDLE, REQUEST, BURST, NEXT, WAIT_LINE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  beat_cnt;
  logic [9:0]  word_index;
  logic        write_bank;
  logic        drop;        // discard the rest of a burst cut short by newScreen
  logic [10:0] line_cnt;    // nextLine strobes seen this frame (k)
  logic [10:0] allowed;     // lines the display has released for fetching
  logic [10:0] pending;

  logic frame_start, line_evt, beat, last_beat;

  assign frame_start = newScreen & enable;
  assign line_evt    = nextLine & ~newScreen & (state != IDLE);
  assign beat        = (state == BURST) & busDataValid;
  assign last_beat   = beat & (beat_cnt == 8'(BURST_SIZE - 1));

  // Lines released but not yet complete: 1 = fetch in progress, 2 = one queued.
  assign pending     = allowed - {1'b0, fetchedLines};

  assign busRequest   = (state == REQUEST);
  assign busBurstSize = 8'(BURST_SIZE - 1);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (frame_start) state_nxt = REQUEST;
      // A grant is always honoured; newScreen before grant withdraws the
      // request for one cycle and the restarted frame requests again.
      REQUEST: if (busGrant) state_nxt = BURST;
               else if (frame_start) state_nxt = NEXT;
      BURST:   if (last_beat) state_nxt = NEXT;
      NEXT, WAIT_LINE: begin
        if (!enable)                            state_nxt = IDLE;
        else if (pending != 11'd0 || frame_start) state_nxt = REQUEST;
        else                                    state_nxt = WAIT_LINE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pixelClockIn) begin
    if (!resetN) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      word_index   <= '0;
      write_bank   <= 1'b0;
      drop         <= 1'b0;
      line_cnt     <= '0;
      allowed      <= '0;
      busAddress   <= '0;
      lineBufWe    <= 1'b0;
      lineBufAddr  <= '0;
      lineBufData  <= '0;
      readBank     <= 1'b0;
      underrun     <= 1'b0;
      fetchedLines <= '0;
    end else begin
      state     <= state_nxt;
      lineBufWe <= 1'b0;

      if (state == REQUEST && busGrant) beat_cnt <= '0;

      // Word position and line count advance when the beat is taken, so the
      // NEXT state already sees the completed line; the write lands a cycle later.
      if (beat) begin
        beat_cnt <= beat_cnt + 8'd1;
        if (!drop) begin
          lineBufWe   <= 1'b1;
          lineBufAddr <= {write_bank, word_index};
          lineBufData <= busData;
          if (word_index == 10'(LINE_WORDS - 1)) begin
            word_index   <= '0;
            fetchedLines <= fetchedLines + 10'd1;
            write_bank   <= ~write_bank;
          end else begin
            word_index <= word_index + 10'd1;
          end
        end
        if (last_beat) begin
          drop <= 1'b0;
          if (!drop) busAddress <= busAddress + 32'(BURST_SIZE * 4);
        end
      end

      if (frame_start) begin
        // newScreen overrides any beat taken in the same cycle.
        busAddress   <= frameBufferBase;
        underrun     <= 1'b0;
        fetchedLines <= '0;
        word_index   <= '0;
        readBank     <= 1'b0;
        write_bank   <= 1'b0;
        line_cnt     <= '0;
        allowed      <= 11'd2;
        lineBufWe    <= 1'b0;
        drop         <= (state == REQUEST && busGrant) || (state == BURST && !last_beat);
      end else if (line_evt) begin
        readBank <= ~readBank;
        line_cnt <= line_cnt + 11'd1;
        if ({1'b0, fetchedLines} < line_cnt + 11'd2) underrun <= 1'b1;
        // Release line k+2 unless one line is already queued behind the active fetch.
        if ((line_cnt + 11'd2 < 11'(NR_OF_LINES)) && (pending < 11'd2))
          allowed <= allowed + 11'd1;
      end
    end
  end

endmodule
